// File: rtl/tlb_miss_handler.sv
// rtl/tlb_miss_handler.sv - TLB refill engine: PTE fetch over a read master, install via config writes
// The writes go to the low word, then the high word, then the trigger. The trigger carries a round-robin way.
module tlb_miss_handler #(
    parameter int          LOG_PAGESIZE = 13,
    parameter logic [31:0] TLB_CFG_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_i,
    input  logic [31:0] miss_adr_i,
    input  logic [15:0] miss_asid_i,
    output logic        missack_o,
    input  logic [31:0] ptbr_i,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic [7:0]  mem_sel_o,
    output logic [31:0] mem_adr_o,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    input  logic [63:0] mem_dat_i,
    output logic        tlb_cyc_o,
    output logic        tlb_stb_o,
    output logic        tlb_we_o,
    output logic [7:0]  tlb_sel_o,
    output logic [31:0] tlb_adr_o,
    output logic [63:0] tlb_dat_o,
    input  logic        tlb_ack_i,
    output logic        tlb_hold_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] fault_adr_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_CHECK, S_WR_WAIT, S_WR_NEXT, S_DONE, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] miss_adr_q, miss_adr_d;
    logic [15:0] miss_asid_q, miss_asid_d;
    logic [63:0] pte_q, pte_d;
    logic [1:0]  widx_q, widx_d;
    logic [1:0]  way_q, way_d;
    logic        missack_q, missack_d;
    logic        mem_cyc_q, mem_cyc_d;
    logic [7:0]  mem_sel_q, mem_sel_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic        tlb_cyc_q, tlb_cyc_d;
    logic [7:0]  tlb_sel_q, tlb_sel_d;
    logic [31:0] tlb_adr_q, tlb_adr_d;
    logic [63:0] tlb_dat_q, tlb_dat_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_adr_q, fault_adr_d;
    logic [31:0] pte_off;
    logic [31:0] wr_adr;
    logic [63:0] wr_dat;

    assign pte_off = 32'({miss_adr_i[31:LOG_PAGESIZE], 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (miss_i) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_err_i)      state_d = S_FAULT;
                else if (mem_ack_i) state_d = S_CHECK;
            end
            S_CHECK:   state_d = pte_q[0] ? S_WR_WAIT : S_FAULT;
            S_WR_WAIT: if (tlb_ack_i) state_d = (widx_q == 2'd2) ? S_DONE : S_WR_NEXT;
            S_WR_NEXT: state_d = S_WR_WAIT;
            S_DONE:    state_d = S_IDLE;
            S_FAULT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Register address/data for the write selected by widx_q (already advanced when WR_NEXT issues it).
    always_comb begin
        case (widx_q)
            2'd0: begin
                wr_adr = TLB_CFG_BASE;
                wr_dat = pte_q;
            end
            2'd1: begin
                wr_adr = TLB_CFG_BASE + 32'h08;
                wr_dat = {32'(miss_adr_q[31:LOG_PAGESIZE+9]), 16'h0, miss_asid_q};
            end
            default: begin
                wr_adr = TLB_CFG_BASE + 32'h20;
                wr_dat = {32'h0, 1'b1, 13'h0, way_q, 7'h0,
                          miss_adr_q[LOG_PAGESIZE+8:LOG_PAGESIZE]};
            end
        endcase
    end

    always_comb begin
        miss_adr_d  = miss_adr_q;
        miss_asid_d = miss_asid_q;
        pte_d       = pte_q;
        widx_d      = widx_q;
        way_d       = way_q;
        missack_d   = 1'b0;
        mem_cyc_d   = (state_d == S_RD_WAIT);
        mem_sel_d   = mem_cyc_d ? 8'hFF : 8'h00;
        mem_adr_d   = mem_adr_q;
        tlb_cyc_d   = (state_d == S_WR_WAIT);
        tlb_sel_d   = tlb_cyc_d ? 8'hFF : 8'h00;
        tlb_adr_d   = tlb_adr_q;
        tlb_dat_d   = tlb_dat_q;
        hold_d      = (state_d == S_RD_WAIT) || (state_d == S_CHECK) ||
                      (state_d == S_WR_WAIT) || (state_d == S_WR_NEXT);
        done_d      = (state_d == S_DONE);
        fault_d     = (state_d == S_FAULT);
        fault_adr_d = fault_adr_q;
        case (state_q)
            S_IDLE: begin
                if (miss_i) begin
                    miss_adr_d  = miss_adr_i;
                    miss_asid_d = miss_asid_i;
                    missack_d   = 1'b1;
                    mem_adr_d   = ptbr_i + pte_off;
                    widx_d      = 2'd0;
                end
            end
            S_RD_WAIT: if (mem_ack_i && !mem_err_i) pte_d = mem_dat_i;
            S_WR_WAIT: if (tlb_ack_i) widx_d = widx_q + 2'd1;
            S_DONE:    way_d = way_q + 2'd1;
            default:   ;
        endcase
        if (state_d == S_FAULT) fault_adr_d = miss_adr_q;
        if ((state_d == S_WR_WAIT) && (state_q != S_WR_WAIT)) begin
            tlb_adr_d = wr_adr;
            tlb_dat_d = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_adr_q  <= 32'h0;
            miss_asid_q <= 16'h0;
            pte_q       <= 64'h0;
            widx_q      <= 2'd0;
            way_q       <= 2'd0;
            missack_q   <= 1'b0;
            mem_cyc_q   <= 1'b0;
            mem_sel_q   <= 8'h00;
            mem_adr_q   <= 32'h0;
            tlb_cyc_q   <= 1'b0;
            tlb_sel_q   <= 8'h00;
            tlb_adr_q   <= 32'h0;
            tlb_dat_q   <= 64'h0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            fault_adr_q <= 32'h0;
        end else begin
            miss_adr_q  <= miss_adr_d;
            miss_asid_q <= miss_asid_d;
            pte_q       <= pte_d;
            widx_q      <= widx_d;
            way_q       <= way_d;
            missack_q   <= missack_d;
            mem_cyc_q   <= mem_cyc_d;
            mem_sel_q   <= mem_sel_d;
            mem_adr_q   <= mem_adr_d;
            tlb_cyc_q   <= tlb_cyc_d;
            tlb_sel_q   <= tlb_sel_d;
            tlb_adr_q   <= tlb_adr_d;
            tlb_dat_q   <= tlb_dat_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
        end
    end

    assign missack_o   = missack_q;
    assign mem_cyc_o   = mem_cyc_q;
    assign mem_stb_o   = mem_cyc_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_adr_o   = mem_adr_q;
    assign tlb_cyc_o   = tlb_cyc_q;
    assign tlb_stb_o   = tlb_cyc_q;
    assign tlb_we_o    = tlb_cyc_q;
    assign tlb_sel_o   = tlb_sel_q;
    assign tlb_adr_o   = tlb_adr_q;
    assign tlb_dat_o   = tlb_dat_q;
    assign tlb_hold_o  = hold_q;
    assign done_o      = done_q;
    assign fault_o     = fault_q;
    assign fault_adr_o = fault_adr_q;

endmodule
